// File: rtl/mult_drain_scheduler.sv
// Round-robin drain of per-channel product FIFOs into one registered product stream.
// Each job is bounded by a programmed product count and ends with a done pulse.
module mult_drain_scheduler #(
  parameter int channel_num = 4,
  parameter int val_bits    = 16,
  parameter int chan_bits   = 2,
  parameter int cnt_bits    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [cnt_bits-1:0]               total_count,
  input  logic [val_bits*2*channel_num-1:0] mult,
  input  logic [channel_num-1:0]            mult_fifo_empty,
  output logic [channel_num-1:0]            mult_fifo_read,
  output logic [2*val_bits-1:0]             out_data,
  output logic [chan_bits-1:0]              out_chan,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              done
);

  localparam int prod_bits = 2 * val_bits;
  localparam logic [cnt_bits-1:0]  cnt_one = cnt_bits'(1);
  localparam logic [chan_bits-1:0] ptr_rst = chan_bits'(channel_num - 1);

  typedef enum logic [1:0] {IDLE, ARB, CAPTURE} state_t;
  state_t state, state_nxt;

  logic [prod_bits-1:0] mult_arr [channel_num];
  logic [chan_bits-1:0] rr_ptr;
  logic [chan_bits-1:0] cand;
  logic [chan_bits-1:0] gnt_p0;
  logic                 gnt_vld_p0;
  logic [chan_bits-1:0] gnt_p1;
  logic                 rd_en;
  logic                 xfer;
  logic                 last_xfer;
  logic [cnt_bits-1:0]  total;
  logic [cnt_bits-1:0]  issued;
  logic [cnt_bits-1:0]  accepted;

  for (genvar i = 0; i < channel_num; i++) begin : g_unpack
    assign mult_arr[i] = mult[i*prod_bits +: prod_bits];
  end

  assign xfer      = out_valid && out_ready;
  assign last_xfer = xfer && (accepted + cnt_one == total);

  // Search downward so the channel closest after rr_ptr is the last one written.
  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_p0     = '0;
    cand       = '0;
    for (int k = channel_num; k >= 1; k--) begin
      cand = chan_bits'((int'(rr_ptr) + k) % channel_num);
      if (!mult_fifo_empty[cand]) begin
        gnt_vld_p0 = 1'b1;
        gnt_p0     = cand;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    rd_en          = 1'b0;
    mult_fifo_read = '0;
    case (state)
      IDLE: begin
        if (start && total_count != '0) state_nxt = ARB;
      end
      ARB: begin
        if (last_xfer) begin
          state_nxt = IDLE;
        end else if (issued < total && gnt_vld_p0 && (!out_valid || out_ready)) begin
          rd_en                  = 1'b1;
          mult_fifo_read[gnt_p0] = 1'b1;
          state_nxt              = CAPTURE;
        end
      end
      CAPTURE: state_nxt = ARB;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Stage p0: grant/read issue.  Stage p1: FIFO dout valid, loaded into the output slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= ptr_rst;
      gnt_p1    <= '0;
      total     <= '0;
      issued    <= '0;
      accepted  <= '0;
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        if (total_count != '0) begin
          total    <= total_count;
          issued   <= '0;
          accepted <= '0;
          busy     <= 1'b1;
        end else begin
          done <= 1'b1;
        end
      end
      if (rd_en) begin
        rr_ptr <= gnt_p0;
        gnt_p1 <= gnt_p0;
        issued <= issued + cnt_one;
      end
      if (state == CAPTURE) begin
        out_data  <= mult_arr[gnt_p1];
        out_chan  <= gnt_p1;
        out_valid <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (xfer) accepted <= accepted + cnt_one;
      if (last_xfer) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mult_drain_scheduler.md
Name: mult_drain_scheduler

Overview:
Drains the per-channel product FIFOs of the multiply channels into one serial product stream for the downstream accumulator. It grants channels round-robin, issues one FIFO read per grant, and registers the product with its channel index. A programmed product count bounds each job, and the block signals done when that many products have been accepted downstream.

Parameters:
channel_num, 4, number of multiply channels and product FIFOs
val_bits, 16, operand width; products are 2*val_bits wide
chan_bits, 2, channel index width; must satisfy 2^chan_bits >= channel_num
cnt_bits, 16, job product counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse that begins a job; ignored while busy
total_count  in  cnt_bits  products in the job; sampled on an accepted start
mult  in  val_bits*2*channel_num  product FIFO dout buses; channel i at [i*2*val_bits +: 2*val_bits]
mult_fifo_empty  in  channel_num  product FIFO empty flags
mult_fifo_read  out  channel_num  product FIFO read strobes; one-hot or zero
out_data  out  2*val_bits  registered product
out_chan  out  chan_bits  source channel of out_data
out_valid  out  1  out_data/out_chan valid
out_ready  in  1  downstream accept; transfer occurs when out_valid && out_ready
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last product of the job transfers

Behaviour:
- Reset (rst=0, asynchronous) sets: mult_fifo_read=0, out_valid=0, out_data=0, out_chan=0, busy=0, done=0, issued=0, accepted=0, rr_ptr=channel_num-1, state=IDLE. Reset mid-job abandons the job; a product already in flight from a FIFO is discarded.
- The FIFO read model is standard (non-FWFT): dout is valid on the cycle after rd_en.
- State IDLE:
  - On start with total_count!=0: latch total_count, clear issued and accepted, set busy, go to ARB.
  - On start with total_count==0: pulse done the next cycle; busy stays 0.
- State ARB: a read is issued only when all of the following hold:
  - issued < total;
  - at least one FIFO is non-empty;
  - the output slot is free this cycle (out_valid==0, or out_valid && out_ready).
- Grant selection in ARB:
  - The grant goes to the first non-empty channel searching rr_ptr+1, rr_ptr+2, ... wrapping modulo channel_num.
  - Drive mult_fifo_read[g]=1 for exactly that cycle.
  - Set rr_ptr=g and increment issued, then go to CAPTURE. Otherwise stay in ARB with mult_fifo_read=0.
- State CAPTURE: load out_data from the granted channel's mult slice and out_chan from the grant index, set out_valid=1, return to ARB. mult_fifo_read=0 in CAPTURE.
- Throughput is at most one product per 2 cycles. Read-to-out_valid latency is 2 cycles.
- Output hold: out_valid stays high and out_data/out_chan stay stable until the transfer; out_valid clears on the transfer unless CAPTURE loads in the same cycle (that cannot occur by construction).
- Counting: accepted increments on each transfer. When the transfer makes accepted==total:
  - done pulses on the next cycle;
  - busy clears on the next cycle;
  - state returns to IDLE.
- Simultaneous events: start received while busy is ignored. A FIFO that goes empty on the grant cycle is never read, because the grant is computed from the current empty flags.
- Width: products pass through unmodified. No arithmetic is performed on the data.

Test Plan:
- Single channel: total_count=3, only FIFO 2 holds 0x0001,0xFFFE,0x0100, out_ready=1 -> three reads of ch2 spaced 2 cycles apart; out_data sequence 0x0001,0xFFFE,0x0100 with out_chan=2; done one cycle after the third transfer; busy 0 afterwards.
- Round-robin fairness: all 4 FIFOs hold 2 entries each, total_count=8 -> grant order 0,1,2,3,0,1,2,3; mult_fifo_read always one-hot.
- Backpressure: out_ready=0 for 5 cycles with out_valid high -> out_data stable and no new read issued; after out_ready rises, the next read is issued in that same cycle.
- Count bound: total_count=2 while FIFOs hold 6 entries -> exactly 2 reads issued; the remaining entries are untouched; done pulses once.
- Zero job and ignored start: start with total_count=0 -> done next cycle, no reads; a second start while busy -> no effect on the latched total.
- Reset mid-job: assert rst low in CAPTURE -> all outputs 0 immediately (asynchronously), rr_ptr reset; the next job's first grant goes to the lowest non-empty channel.
